pipe_sum_final: RTL

//   Final reduction stage of the matrix-multiply datapath, directly downstream of the

---
 rtl/pipe_sum_final_pkg.sv | 19 +
 rtl/pipe_sum_final_add.sv | 34 +++
 rtl/pipe_sum_final.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_sum_final_pkg.sv
// Shared constants for the final reduction stage of the matrix-multiply datapath.
// Element width and matrix dimension match the upstream partial-sum stage.
package pipe_sum_final_pkg;

    // Element width in bits, signed fixed point.
    localparam int WORD_LEN   = 32;
    // Elements per row and rows per matrix; must be a power of two.
    localparam int MATRIX_DIM = 8;
    // Width of the column and row indices.
    localparam int IDX_W      = $clog2(MATRIX_DIM);
    // Number of partial-sum lanes entering the adder tree each cycle.
    localparam int LANES      = 4;

    // True when an index addresses the last element of a row (or the last row).
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(MATRIX_DIM - 1);
    endfunction

endpackage : pipe_sum_final_pkg

// File: rtl/pipe_sum_final_add.sv
// Registered halving adder node: sum <= (a + b) >>> 1 on signed operands.
// The full sum is formed one bit wider and its top W bits are kept, which is an
// arithmetic shift right by one rounding toward -inf; halving can never overflow.
module pipe_add_half
    import pipe_sum_final_pkg::*;
#(
    parameter int W = WORD_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    logic signed [W:0] full_sum;

    // Sign-extend both operands by one bit so the carry out is kept.
    always_comb begin
        full_sum = {a[W-1], a} + {b[W-1], b};
    end

    // Register the halved sum; reset only so that outputs start at a known zero.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples the
        // pre-edge value of its inputs regardless of block evaluation order.
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= full_sum[W:1];
        end
    end

endmodule : pipe_add_half

// File: rtl/pipe_sum_final.sv
// Final reduction stage: reduces four signed partial sums per cycle through a
// two-level pipelined halving adder tree, collects MATRIX_DIM consecutive
// elements into a row, and flags row and matrix completion.
module pipe_sum_final
    import pipe_sum_final_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               we_in,
    input  logic [LANES*WORD_LEN-1:0]          partial_sum_0,
    output logic                               we_out,
    output logic signed [WORD_LEN-1:0]         dot_out,
    output logic [IDX_W-1:0]                   col_idx,
    output logic                               row_valid,
    output logic [MATRIX_DIM*WORD_LEN-1:0]     row_data,
    output logic [IDX_W-1:0]                   row_idx,
    output logic                               mat_done
);

    // ------------------------------------------------------------------
    // Adder tree
    // ------------------------------------------------------------------
    logic signed [WORD_LEN-1:0] lane [LANES];
    logic signed [WORD_LEN-1:0] s0;
    logic signed [WORD_LEN-1:0] s1;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane[k] = partial_sum_0[k*WORD_LEN +: WORD_LEN];
    end

    // Stage A: pairwise halving sums of the four lanes.
    pipe_add_half #(.W(WORD_LEN)) u_add_a0 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (lane[0]),
        .b     (lane[1]),
        .sum   (s0)
    );

    pipe_add_half #(.W(WORD_LEN)) u_add_a1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (lane[2]),
        .b     (lane[3]),
        .sum   (s1)
    );

    // Stage B: halving sum of the two stage-A results is the output element.
    pipe_add_half #(.W(WORD_LEN)) u_add_b (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (s0),
        .b     (s1),
        .sum   (dot_out)
    );

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic                       valid_a;
    logic [IDX_W-1:0]           row_cnt;
    logic [WORD_LEN-1:0]        shadow [MATRIX_DIM];
    logic [MATRIX_DIM*WORD_LEN-1:0] row_next;
    logic                       elem_accept;
    logic                       row_last;

    // An output element is consumed unless a clear wins this cycle.
    always_comb begin
        // NOTE: every signal written in always_comb gets a value on every path
        // (here unconditionally) so no latch is inferred.
        elem_accept = we_out && !clr;
        row_last    = elem_accept && is_last_idx(col_idx);
    end

    // Assemble the completed row: stored slots plus the element arriving now.
    always_comb begin
        row_next = '0;
        for (int k = 0; k < MATRIX_DIM; k++) begin
            if (IDX_W'(k) == col_idx) begin
                row_next[k*WORD_LEN +: WORD_LEN] = dot_out;
            end else begin
                row_next[k*WORD_LEN +: WORD_LEN] = shadow[k];
            end
        end
    end

    // Valid pipeline tracking the two adder levels; clear drops in-flight elements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_a <= 1'b0;
            we_out  <= 1'b0;
        end else if (clr) begin
            valid_a <= 1'b0;
            we_out  <= 1'b0;
        end else begin
            valid_a <= we_in;
            we_out  <= valid_a;
        end
    end

    // Column and row counters advance only on accepted output elements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_idx <= '0;
            row_cnt <= '0;
        end else if (clr) begin
            col_idx <= '0;
            row_cnt <= '0;
        end else if (elem_accept) begin
            col_idx <= col_idx + IDX_W'(1);
            if (row_last) begin
                row_cnt <= row_cnt + IDX_W'(1);
            end
        end
    end

    // Shadow row collects elements of the row currently being built.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is deliberately reset, because a reset
        // must leave no stale row data behind; a RAM-style array would not be.
        if (!rst_n) begin
            for (int k = 0; k < MATRIX_DIM; k++) begin
                shadow[k] <= '0;
            end
        end else if (elem_accept) begin
            shadow[col_idx] <= dot_out;
        end
    end

    // Output row register and completion pulses; row_data holds until the next row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_data  <= '0;
            row_idx   <= '0;
            row_valid <= 1'b0;
            mat_done  <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            mat_done  <= 1'b0;
            if (row_last) begin
                row_data  <= row_next;
                row_idx   <= row_cnt;
                row_valid <= 1'b1;
                mat_done  <= is_last_idx(row_cnt);
            end
        end
    end

endmodule : pipe_sum_final
